// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, single-outstanding imem requests,
// IF/ID register with a one-entry stall hold buffer and EX redirect flushing.
module fetch_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  id_valid,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_instr
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   pc_r, pc_s;
    logic [ADDR_WIDTH-1:0]   req_pc_r, req_pc_s;
    logic                    drop_r, drop_s;
    logic [DATA_WIDTH-1:0]   hold_instr_r, hold_instr_s;
    logic [ADDR_WIDTH-1:0]   hold_pc_r, hold_pc_s;
    logic                    run_r;
    logic                    id_valid_r, id_valid_s;
    logic [ADDR_WIDTH-1:0]   id_pc_r, id_pc_s;
    logic [DATA_WIDTH-1:0]   id_instr_r, id_instr_s;
    logic                    load_s;
    logic [ADDR_WIDTH-1:0]   load_pc_s;
    logic [DATA_WIDTH-1:0]   load_instr_s;
    logic                    gnt_s;

    // run_r keeps the request line low for the first cycle after reset release
    assign gnt_s     = run_r & imem_gnt;
    assign imem_req  = run_r & (state_r == S_REQ);
    assign imem_addr = pc_r;
    assign id_valid  = id_valid_r;
    assign id_pc     = id_pc_r;
    assign id_instr  = id_instr_r;

    // Next-state, PC and IF/ID logic; redirect overrides everything else
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        req_pc_s     = req_pc_r;
        drop_s       = drop_r;
        hold_instr_s = hold_instr_r;
        hold_pc_s    = hold_pc_r;
        load_s       = 1'b0;
        load_pc_s    = req_pc_r;
        load_instr_s = imem_rdata;

        case (state_r)
            S_REQ: begin
                if (gnt_s) begin
                    req_pc_s = pc_r;
                    pc_s     = pc_r + ADDR_WIDTH'(32'd4);
                    state_s  = S_WAIT;
                end else begin
                    state_s  = S_REQ;
                end
            end
            S_WAIT: begin
                if (!imem_rvalid) begin
                    state_s = S_WAIT;
                end else if (drop_r) begin
                    drop_s  = 1'b0;
                    state_s = S_REQ;
                end else if (!stall) begin
                    load_s  = 1'b1;
                    state_s = S_REQ;
                end else begin
                    hold_instr_s = imem_rdata;
                    hold_pc_s    = req_pc_r;
                    state_s      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    load_s       = 1'b1;
                    load_pc_s    = hold_pc_r;
                    load_instr_s = hold_instr_r;
                    state_s      = S_REQ;
                end else begin
                    state_s      = S_HOLD;
                end
            end
            default: state_s = S_REQ;
        endcase

        if (load_s) begin
            id_valid_s = 1'b1;
            id_pc_s    = load_pc_s;
            id_instr_s = load_instr_s;
        end else if (stall) begin
            id_valid_s = id_valid_r;
            id_pc_s    = id_pc_r;
            id_instr_s = id_instr_r;
        end else begin
            id_valid_s = 1'b0;
            id_pc_s    = id_pc_r;
            id_instr_s = NOP;
        end

        if (redirect_valid) begin
            pc_s       = redirect_pc;
            id_valid_s = 1'b0;
            id_pc_s    = id_pc_r;
            id_instr_s = NOP;
            case (state_r)
                S_REQ: begin
                    // a request granted alongside the redirect is already stale
                    if (gnt_s) begin
                        req_pc_s = pc_r;
                        drop_s   = 1'b1;
                        state_s  = S_WAIT;
                    end else begin
                        drop_s   = drop_r;
                        state_s  = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop_s  = 1'b0;
                        state_s = S_REQ;
                    end else begin
                        drop_s  = 1'b1;
                        state_s = S_WAIT;
                    end
                end
                S_HOLD:  state_s = S_REQ;
                default: state_s = S_REQ;
            endcase
        end else begin
            drop_s = drop_s;
        end
    end

    // State and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_REQ;
            pc_r         <= RESET_PC;
            req_pc_r     <= '0;
            drop_r       <= 1'b0;
            hold_instr_r <= NOP;
            hold_pc_r    <= '0;
            run_r        <= 1'b0;
            id_valid_r   <= 1'b0;
            id_pc_r      <= '0;
            id_instr_r   <= NOP;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            req_pc_r     <= req_pc_s;
            drop_r       <= drop_s;
            hold_instr_r <= hold_instr_s;
            hold_pc_r    <= hold_pc_s;
            run_r        <= 1'b1;
            id_valid_r   <= id_valid_s;
            id_pc_r      <= id_pc_s;
            id_instr_r   <= id_instr_s;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; the memory returns the
// granted address as the instruction word so id_instr can be predicted.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_gnt = 32'h0;

    fetch_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        gnt;
        logic        rvalid;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_idv;
        logic [31:0] exp_idpc;
    } vec_t;

    vec_t vecs [29];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: drive inputs at negedge, memory answers with the last granted address
    task automatic tick(input logic st, input logic rv, input logic [31:0] rpc,
                        input logic g, input logic rval);
        logic        granted;
        logic [31:0] gaddr;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_gnt       = g;
        imem_rvalid    = rval;
        imem_rdata     = last_gnt;
        granted        = imem_req & g;
        gaddr          = imem_addr;
        @(posedge clk);
        @(negedge clk);
        if (granted) last_gnt = gaddr;
    endtask

    task automatic check_out(input string tag, input logic req, input logic [31:0] addr,
                             input logic idv, input logic [31:0] idpc);
        check({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, req});
        check({tag, " imem_addr"}, imem_addr, addr);
        check({tag, " id_valid"}, {31'd0, id_valid}, {31'd0, idv});
        check({tag, " id_pc"}, id_pc, idpc);
        check({tag, " id_instr"}, id_instr, idv ? idpc : NOP);
    endtask

    initial begin
        // stall rv rpc gnt rvalid | req addr idv idpc
        vecs[0]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_0004, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000};
        vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_0008, 1'b0, 32'h8000_0000};
        vecs[4]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004};
        // stall while the response arrives: hold buffer
        vecs[5]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_000C, 1'b1, 32'h8000_0004};
        vecs[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h8000_000C, 1'b1, 32'h8000_0004};
        vecs[7]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_000C, 1'b1, 32'h8000_0004};
        vecs[8]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_000C, 1'b1, 32'h8000_0004};
        vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0008};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_0010, 1'b0, 32'h8000_0008};
        // redirect in S_WAIT before the response
        vecs[11] = '{1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b0, 1'b0, 32'h8000_0100, 1'b0, 32'h8000_0008};
        vecs[12] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0008};
        vecs[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_0104, 1'b0, 32'h8000_0008};
        vecs[14] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0104, 1'b1, 32'h8000_0100};
        // redirect coincident with grant
        vecs[15] = '{1'b0, 1'b1, 32'h8000_0200, 1'b1, 1'b0, 1'b0, 32'h8000_0200, 1'b0, 32'h8000_0100};
        vecs[16] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0200, 1'b0, 32'h8000_0100};
        vecs[17] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_0204, 1'b0, 32'h8000_0100};
        vecs[18] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0204, 1'b1, 32'h8000_0200};
        // redirect in S_HOLD under stall
        vecs[19] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_0208, 1'b0, 32'h8000_0200};
        vecs[20] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8000_0208, 1'b0, 32'h8000_0200};
        vecs[21] = '{1'b1, 1'b1, 32'h8000_0300, 1'b0, 1'b0, 1'b1, 32'h8000_0300, 1'b0, 32'h8000_0200};
        vecs[22] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_0304, 1'b0, 32'h8000_0200};
        vecs[23] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0304, 1'b1, 32'h8000_0300};
        // stray rvalid in S_REQ is ignored
        vecs[24] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0304, 1'b0, 32'h8000_0300};
        // redirect to the top of the address space, then wrap
        vecs[25] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h8000_0300};
        vecs[26] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h8000_0300};
        vecs[27] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
        vecs[28] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 32'hFFFF_FFFC};

        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 1'b0, 32'h8000_0000, 1'b0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            tick(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].gnt, vecs[i].rvalid);
            check_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                      vecs[i].exp_idv, vecs[i].exp_idpc);
        end

        // Reset pulse in S_WAIT: immediate reset outputs, late response ignored
        rst_n = 1'b0;
        #1;
        check_out("midrst", 1'b0, 32'h8000_0000, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_out("late_rvalid", 1'b1, 32'h8000_0000, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_out("rst_grant", 1'b0, 32'h8000_0004, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_out("rst_first", 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage core. Owns the program counter, issues one-outstanding requests to instruction memory, and drives the IF/ID pipeline register consumed by the decoder. Handles hazard-unit stalls with a one-entry hold buffer and EX-stage redirects (taken branch, jal/jalr) by flushing IF/ID and discarding any in-flight response.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC/address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hazard unit: hold IF/ID contents (load-use)
- redirect_valid  in  1  EX: control transfer taken this cycle
- redirect_pc  in  ADDR_WIDTH  EX: target PC
- imem_req  out  1  request valid
- imem_addr  out  ADDR_WIDTH  request address (= pc)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  DATA_WIDTH  response instruction
- id_valid  out  1  IF/ID holds a real instruction
- id_pc  out  ADDR_WIDTH  PC of id_instr
- id_instr  out  DATA_WIDTH  instruction to decoder; NOP 32'h0000_0013 when id_valid=0

## Operation
- State: pc, req_pc, drop flag, hold buffer (instr + pc), FSM S_REQ / S_WAIT / S_HOLD.
- S_REQ: imem_req=1, imem_addr=pc. On imem_gnt: req_pc<=pc, pc<=pc+4 (mod 2^ADDR_WIDTH, wrap silent), -> S_WAIT.
- S_WAIT: imem_req=0. On imem_rvalid:
  - drop=1: discard data, drop<=0, -> S_REQ.
  - stall=0: id_valid<=1, id_pc<=req_pc, id_instr<=imem_rdata, -> S_REQ.
  - stall=1: capture into hold buffer, -> S_HOLD.
- S_HOLD: imem_req=0. When stall=0: buffer -> IF/ID (id_valid<=1), -> S_REQ.
- IF/ID when no new instruction enters: stall=1 holds contents; stall=0 loads bubble (id_valid<=0, id_instr<=NOP, id_pc unchanged).
- Redirect (highest priority, overrides stall and everything above):
  - pc<=redirect_pc; IF/ID flushed to bubble.
  - In S_WAIT without rvalid: drop<=1, stay S_WAIT. In S_WAIT with rvalid same cycle: data discarded, -> S_REQ.
  - In S_REQ with imem_gnt same cycle: pc<=redirect_pc (not pc+4), drop<=1, -> S_WAIT.
  - In S_HOLD: buffer discarded, -> S_REQ.
- imem_rvalid outside S_WAIT is ignored.
- redirect_pc used as-is; misalignment not checked.

## Timing
- Reset (async assert): pc=RESET_PC, state=S_REQ, drop=0, id_valid=0, id_pc=0, id_instr=32'h0000_0013, imem_req=0 while rst_n=0; first request the cycle after release.
- imem_req/imem_addr are registered-state outputs (combinational from state and pc only; no input-to-output path).
- Latency: gnt at cycle N, rvalid at N+1 -> id_* valid from edge ending N+1.
- Zero-wait memory (gnt=1, rvalid one cycle later): one instruction per 2 cycles.
- Redirect at cycle N: IF/ID bubble after edge N; request to redirect_pc no earlier than N+1 (or N+2 if a drop is pending).
- Reset mid-transaction: in-flight response after release is ignored (state S_REQ).

## Test plan
- Reset release, gnt=1, rvalid next cycle, rdata=pc: id_pc sequence 0x80000000, 0x80000004, 0x80000008 at 2-cycle spacing; id_instr=NOP and id_valid=0 during reset.
- stall=1 for 3 cycles while response for 0x80000004 arrives: IF/ID keeps 0x80000000; after stall drops, 0x80000004 enters next edge; no request issued while in S_HOLD.
- redirect_valid=1, redirect_pc=0x80000100 in S_WAIT: response discarded, id_valid=0 next edge, next imem_addr=0x80000100, next id_pc=0x80000100.
- redirect coincident with imem_gnt in S_REQ: that response dropped, following request at redirect_pc.
- redirect in S_HOLD with stall=1: buffer discarded, IF/ID bubble, next request at target.
- pc=0xFFFFFFFC granted: next imem_addr=0x00000000; rst_n pulsed low mid-S_WAIT: outputs return to reset values immediately, late rvalid ignored.
